// File: rtl/str_pack_pkg.sv
// Shared types and constants for the streaming
// string-to-vector packer.
package str_pack_pkg;

  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] CHAR_NUL = 8'h00;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int len_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/str_pack_acc.sv
// Shift accumulator with saturating count and truncation flag.
// The fold_* ports show the state with the current char applied.
module str_pack_acc
  import str_pack_pkg::*;
#(
  parameter int NCHARS   = 4,
  parameter bit KEEP_LOW = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           char_en,
  input  logic [CHAR_W-1:0]              char_in,
  output logic [NCHARS*CHAR_W-1:0]       fold_data,
  output logic [len_w(NCHARS)-1:0]       fold_len,
  output logic                           fold_trunc
);

  localparam int DW = NCHARS * CHAR_W;
  localparam int LW = len_w(NCHARS);
  localparam logic [LW-1:0] FULL = LW'(NCHARS);

  logic [DW-1:0] acc;
  logic [LW-1:0] cnt;
  logic          trunc;
  logic [DW-1:0] shifted;

  if (NCHARS == 1) begin : g_one
    assign shifted = char_in;
  end else begin : g_wide
    assign shifted = {acc[DW-CHAR_W-1:0], char_in};
  end

  always_comb begin
    fold_data  = acc;
    fold_len   = cnt;
    fold_trunc = trunc;
    if (char_en) begin
      if (KEEP_LOW) begin
        fold_data = shifted;
        if (cnt == FULL) fold_trunc = 1'b1;
        else             fold_len   = cnt + LW'(1);
      end else if (cnt < FULL) begin
        fold_data = shifted;
        fold_len  = cnt + LW'(1);
      end else begin
        fold_trunc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc   <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
    end else begin
      acc   <= fold_data;
      cnt   <= fold_len;
      trunc <= fold_trunc;
    end
  end

endmodule

// File: rtl/str_pack_cast.sv
// Streaming packer: ASCII beats into a right-aligned,
// zero-filled vector with valid/ready on both sides.
module str_pack_cast
  import str_pack_pkg::*;
#(
  parameter int NCHARS   = 4,
  parameter bit KEEP_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHAR_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NCHARS*CHAR_W-1:0]  out_data,
  output logic [len_w(NCHARS)-1:0]  out_len,
  output logic                      out_trunc
);

  localparam int DW = NCHARS * CHAR_W;
  localparam int LW = len_w(NCHARS);

  state_e state, state_nxt;

  logic          take_in;
  logic          take_last;
  logic          char_en;
  logic [DW-1:0] fold_data;
  logic [LW-1:0] fold_len;
  logic          fold_trunc;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign take_in   = in_valid & in_ready;
  assign take_last = take_in & in_last;
  assign char_en   = take_in & (in_data != CHAR_NUL);

  str_pack_acc #(
    .NCHARS   (NCHARS),
    .KEEP_LOW (KEEP_LOW)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr        (take_last),
    .char_en    (char_en),
    .char_in    (in_data),
    .fold_data  (fold_data),
    .fold_len   (fold_len),
    .fold_trunc (fold_trunc)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM: if (take_last) state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Result regs keep the last string after hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_len   <= '0;
      out_trunc <= 1'b0;
    end else if (take_last) begin
      out_data  <= fold_data;
      out_len   <= fold_len;
      out_trunc <= fold_trunc;
    end
  end

endmodule

// File: tb/tb_str_pack_cast.sv
// Bench for str_pack_cast: six parameterisations in lockstep
// against a queue-based model of string-cast semantics.
module tb_str_pack_cast;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic r4l, r4f, r7, r11, r1l, r1f;
  logic v4l, v4f, v7, v11, v1l, v1f;
  logic t4l, t4f, t7, t11, t1l, t1f;
  logic [31:0] d4l, d4f;
  logic [55:0] d7;
  logic [87:0] d11;
  logic [7:0]  d1l, d1f;
  logic [2:0]  l4l, l4f, l7;
  logic [3:0]  l11;
  logic [0:0]  l1l, l1f;

  int total = 0;
  int bad = 0;
  byte unsigned q[$];

  always #5 clk = ~clk;

  str_pack_cast #(.NCHARS(4), .KEEP_LOW(1'b1)) u4l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4l),
    .in_data(in_data), .in_last(in_last), .out_valid(v4l),
    .out_ready(out_ready), .out_data(d4l), .out_len(l4l),
    .out_trunc(t4l));
  str_pack_cast #(.NCHARS(4), .KEEP_LOW(1'b0)) u4f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4f),
    .in_data(in_data), .in_last(in_last), .out_valid(v4f),
    .out_ready(out_ready), .out_data(d4f), .out_len(l4f),
    .out_trunc(t4f));
  str_pack_cast #(.NCHARS(7), .KEEP_LOW(1'b1)) u7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r7),
    .in_data(in_data), .in_last(in_last), .out_valid(v7),
    .out_ready(out_ready), .out_data(d7), .out_len(l7),
    .out_trunc(t7));
  str_pack_cast #(.NCHARS(11), .KEEP_LOW(1'b1)) u11 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r11),
    .in_data(in_data), .in_last(in_last), .out_valid(v11),
    .out_ready(out_ready), .out_data(d11), .out_len(l11),
    .out_trunc(t11));
  str_pack_cast #(.NCHARS(1), .KEEP_LOW(1'b1)) u1l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1l),
    .in_data(in_data), .in_last(in_last), .out_valid(v1l),
    .out_ready(out_ready), .out_data(d1l), .out_len(l1l),
    .out_trunc(t1l));
  str_pack_cast #(.NCHARS(1), .KEEP_LOW(1'b0)) u1f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1f),
    .in_data(in_data), .in_last(in_last), .out_valid(v1f),
    .out_ready(out_ready), .out_data(d1f), .out_len(l1f),
    .out_trunc(t1f));

  task automatic chk(input string tag, input logic [87:0] got,
                     input logic [87:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: keep last n (cast) or first n of the non-NUL chars
  function automatic logic [87:0] ed(input int n, input bit kl);
    int sz = q.size();
    int lo, hi;
    logic [87:0] r = '0;
    lo = (kl && sz > n) ? sz - n : 0;
    hi = (!kl && sz > n) ? n : sz;
    for (int i = lo; i < hi; i++) r = (r << 8) | 88'(q[i]);
    return r;
  endfunction

  function automatic logic [87:0] el(input int n);
    return (q.size() > n) ? 88'(n) : 88'(q.size());
  endfunction

  function automatic logic [87:0] et(input int n);
    return (q.size() > n) ? 88'd1 : 88'd0;
  endfunction

  task automatic inst(input string tag, input logic [87:0] d,
                      input logic [87:0] l, input logic [87:0] t,
                      input int n, input bit kl);
    chk({tag, " data"}, d, ed(n, kl));
    chk({tag, " len"}, l, el(n));
    chk({tag, " trunc"}, t, et(n));
  endtask

  task automatic check_state(input string tag, input bit v);
    chk({tag, " valid"}, 88'({v4l, v4f, v7, v11, v1l, v1f}),
        v ? 88'h3f : 88'h0);
    chk({tag, " ready"}, 88'({r4l, r4f, r7, r11, r1l, r1f}),
        v ? 88'h0 : 88'h3f);
    inst({tag, " n4k1"}, 88'(d4l), 88'(l4l), 88'(t4l), 4, 1'b1);
    inst({tag, " n4k0"}, 88'(d4f), 88'(l4f), 88'(t4f), 4, 1'b0);
    inst({tag, " n7k1"}, 88'(d7), 88'(l7), 88'(t7), 7, 1'b1);
    inst({tag, " n11k1"}, d11, 88'(l11), 88'(t11), 11, 1'b1);
    inst({tag, " n1k1"}, 88'(d1l), 88'(l1l), 88'(t1l), 1, 1'b1);
    inst({tag, " n1k0"}, 88'(d1f), 88'(l1f), 88'(t1f), 1, 1'b0);
  endtask

  task automatic beat(input logic [7:0] d, input logic l,
                      input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!r4l && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("beat ready", 88'(r4l), 88'd1);
    if (d != 8'h00) q.push_back(d);
    @(posedge clk);
  endtask

  task automatic finish_str(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    check_state(tag, 1'b1);
  endtask

  task automatic send_str(input string s, input bit nul_last);
    q.delete();
    for (int i = 0; i < s.len(); i++)
      beat(s[i], !nul_last && (i == s.len() - 1), 1'b0);
    if (nul_last) beat(8'h00, 1'b1, 1'b0);
    finish_str(s);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release valid", 88'(v4l), 88'd0);
    chk("release ready", 88'(r4l), 88'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();
    check_state("reset", 1'b0);

    send_str("sm", 1'b0);
    chk("sm const", 88'(d4l), 88'h736d);
    release_out();

    send_str("medium", 1'b0);
    chk("medium k1", 88'(d4l), 88'h6469756d);
    chk("medium k0", 88'(d4f), 88'h6d656469);
    release_out();

    send_str("veryverylongwilltruncate", 1'b0);
    chk("long n7", 88'(d7), 88'h72756e63617465);
    chk("long n11", d11, 88'h696c6c7472756e63617465);
    release_out();

    send_str("zmedi", 1'b0);
    chk("zmedi n11", d11, 88'h7a6d656469);
    release_out();

    send_str("", 1'b1);
    release_out();

    q.delete();
    beat("a", 1'b0, 1'b0);
    beat(8'h00, 1'b0, 1'b0);
    beat("b", 1'b1, 1'b0);
    finish_str("a_nul_b");
    chk("a_nul_b const", 88'(d4l), 88'h6162);
    release_out();

    // Backpressure with a pending source beat held during HOLD
    send_str("sm", 1'b0);
    in_valid = 1'b1;
    in_data = "q";
    in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_state("hold", 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    q.delete();
    q.push_back("q");
    beat("x", 1'b1, 1'b0);
    finish_str("after_hold");
    release_out();

    // Reset mid-string discards partial chars and old result
    q.delete();
    beat("m", 1'b0, 1'b0);
    beat("e", 1'b0, 1'b0);
    beat("d", 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check_state("mid_rst", 1'b0);
    send_str("z", 1'b0);
    chk("z const", 88'(d4l), 88'h7a);

    // Reset while holding a result
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check_state("hold_rst", 1'b0);

    for (int s = 0; s < 30; s++) begin
      int n;
      logic [7:0] c;
      q.delete();
      n = $urandom_range(0, 14);
      for (int i = 0; i < n; i++) begin
        c = ($urandom_range(0, 6) == 0) ? 8'h00
            : 8'($urandom_range(8'h21, 8'h7e));
        beat(c, 1'b0, 1'b1);
      end
      c = ($urandom_range(0, 3) == 0) ? 8'h00
          : 8'($urandom_range(8'h21, 8'h7e));
      beat(c, 1'b1, 1'b1);
      finish_str("rnd");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
